// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the BCD counter run-control sequencer:
// FSM state encoding, the counter's top value and the reachability helper.
package bcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [7:0] BCD_MAX = 8'd99;

    // A target above BCD_MAX can never be matched, so the counter free-runs.
    function automatic logic target_reachable(input logic [7:0] target);
        return (target <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Command/status bundle between the user side, the sequencer and the counter.
interface bcd_count_ctrl_if;

    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] target;
    logic [7:0] cnt_val;
    logic       cnt_ce;
    logic       cnt_init;
    logic       busy;
    logic       paused;
    logic       done;
    logic       done_pulse;

    modport master (
        output start, stop, clear, target, cnt_val,
        input  cnt_ce, cnt_init, busy, paused, done, done_pulse
    );

    modport slave (
        input  start, stop, clear, target, cnt_val,
        output cnt_ce, cnt_init, busy, paused, done, done_pulse
    );

endinterface

// File: rtl/bcd_count_ctrl_tick_gen.sv
// Prescaler producing a single-cycle count-enable tick every TICK_DIV run cycles.
// The count holds while run_i is low, so a paused run resumes mid-period.
module tick_gen #(
    parameter int unsigned TICK_DIV = 10,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // Next prescaler value: clear wins, otherwise count and wrap while running.
    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (run_i) begin
            if (presc_q == LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = run_i && (presc_q == LAST);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a two-digit decimal counter: command FSM,
// target latch, terminal compare and Moore output decode.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_count_ctrl_if.slave  bus
);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] target_q;
    logic [7:0] target_d;
    logic       from_clear_q;
    logic       from_clear_d;
    logic       done_pulse_q;
    logic       done_pulse_d;
    logic       tick_s;
    logic       match_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .PRESC_W  (PRESC_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (state_q == ST_RUN),
        .clr_i  (state_q == ST_INIT),
        .tick_o (tick_s)
    );

    // A match during a tick cycle is stale: the counter is about to move.
    assign match_s = target_reachable(target_q) && (bus.cnt_val == target_q) && !tick_s;

    // Next-state logic with command priority clear > stop > start.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        from_clear_d = from_clear_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.clear) begin
                    state_d      = ST_INIT;
                    from_clear_d = 1'b1;
                end else if (bus.start) begin
                    state_d      = ST_INIT;
                    from_clear_d = 1'b0;
                    target_d     = bus.target;
                end else begin
                    state_d = state_q;
                end
            end
            ST_INIT: begin
                if (from_clear_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear) begin
                    state_d      = ST_INIT;
                    from_clear_d = 1'b1;
                end else if (bus.stop) begin
                    state_d = ST_PAUSE;
                end else if (match_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (bus.clear) begin
                    state_d      = ST_INIT;
                    from_clear_d = 1'b1;
                end else if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);

    // State, target latch, origin flag and first-DONE-cycle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= 8'd0;
            from_clear_q <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            from_clear_q <= from_clear_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign bus.cnt_ce     = tick_s;
    assign bus.cnt_init   = (state_q == ST_INIT);
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.paused     = (state_q == ST_PAUSE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl: two instances (TICK_DIV=4 and 2), each
// driving a behavioural 0..99 binary counter that feeds cnt_val back.
module tb_bcd_count_ctrl;

    logic       clk;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] cnt_a  = 8'd37;
    logic [7:0] cnt_b  = 8'd55;

    bcd_count_ctrl_if if_a ();
    bcd_count_ctrl_if if_b ();

    bcd_count_ctrl #(.TICK_DIV(4), .PRESC_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    bcd_count_ctrl #(.TICK_DIV(2), .PRESC_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    assign if_a.cnt_val = cnt_a;
    assign if_b.cnt_val = cnt_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counters: init to zero, increment on enable, wrap 99 -> 0.
    always @(posedge clk) begin
        if (if_a.cnt_init)     cnt_a <= 8'd0;
        else if (if_a.cnt_ce)  cnt_a <= (cnt_a == 8'd99) ? 8'd0 : cnt_a + 8'd1;
        if (if_b.cnt_init)     cnt_b <= 8'd0;
        else if (if_b.cnt_ce)  cnt_b <= (cnt_b == 8'd99) ? 8'd0 : cnt_b + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {cnt_ce, cnt_init, busy, paused, done, done_pulse}
    function automatic logic [5:0] outs_a();
        return {if_a.cnt_ce, if_a.cnt_init, if_a.busy, if_a.paused, if_a.done, if_a.done_pulse};
    endfunction

    function automatic logic [5:0] outs_b();
        return {if_b.cnt_ce, if_b.cnt_init, if_b.busy, if_b.paused, if_b.done, if_b.done_pulse};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int waited;
        logic [7:0] snap;

        rst_n = 1'b0;
        if_a.start = 1'b0; if_a.stop = 1'b0; if_a.clear = 1'b0; if_a.target = 8'd0;
        if_b.start = 1'b0; if_b.stop = 1'b0; if_b.clear = 1'b0; if_b.target = 8'd0;

        // Reset state
        #1;
        check_eq("rst_outs_a", {26'd0, outs_a()}, 32'd0);
        check_eq("rst_outs_b", {26'd0, outs_b()}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check_eq("idle_after_rst", {26'd0, outs_a()}, 32'd0);

        // Target 3: ticks at RUN cycles 4, 8, 12; DONE two cycles after the third
        if_a.target = 8'd3; if_a.start = 1'b1; step(); if_a.start = 1'b0;
        check_eq("t1_init", {26'd0, outs_a()}, 32'b010000);
        bad = 0;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (if_a.cnt_ce !== ((i % 4) == 0)) bad++;
            if (!if_a.busy || if_a.cnt_init) bad++;
        end
        check_eq("t1_run_pattern", bad, 32'd0);
        check_eq("t1_cnt3", {24'd0, cnt_a}, 32'd3);
        step();
        check_eq("t1_done_first", {26'd0, outs_a()}, 32'b000011);
        step();
        check_eq("t1_done_level", {26'd0, outs_a()}, 32'b000010);
        bad = 0;
        repeat (8) begin
            step();
            if (if_a.cnt_ce || !if_a.done) bad++;
        end
        check_eq("t1_done_hold", bad, 32'd0);
        check_eq("t1_cnt_held", {24'd0, cnt_a}, 32'd3);

        // Target 10 with a pause after the second tick (prescaler held at 2)
        if_a.target = 8'd10; if_a.start = 1'b1; step(); if_a.start = 1'b0;
        check_eq("t2_init", {26'd0, outs_a()}, 32'b010000);
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (if_a.cnt_ce !== ((i % 4) == 0)) bad++;
        end
        check_eq("t2_run_pattern", bad, 32'd0);
        if_a.stop = 1'b1; step(); if_a.stop = 1'b0;
        check_eq("t2_paused", {26'd0, outs_a()}, 32'b000100);
        bad = 0;
        repeat (20) begin
            step();
            if (if_a.cnt_ce || !if_a.paused) bad++;
        end
        check_eq("t2_pause_hold", bad, 32'd0);
        check_eq("t2_cnt2", {24'd0, cnt_a}, 32'd2);
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        check_eq("t2_resume_c1", {26'd0, outs_a()}, 32'b001000);
        step();
        check_eq("t2_resume_tick", {26'd0, outs_a()}, 32'b101000);
        waited = 0;
        while (!if_a.done && waited < 100) begin
            step();
            waited++;
        end
        check_eq("t2_done_latency", waited, 32'd30);
        check_eq("t2_cnt10", {24'd0, cnt_a}, 32'd10);
        check_eq("t2_done_pulse", {31'd0, if_a.done_pulse}, 32'd1);

        // Target 0: DONE after one RUN cycle without a tick
        if_a.target = 8'd0; if_a.start = 1'b1; step(); if_a.start = 1'b0;
        check_eq("t3_init", {26'd0, outs_a()}, 32'b010000);
        step();
        check_eq("t3_run1", {26'd0, outs_a()}, 32'b001000);
        step();
        check_eq("t3_done", {26'd0, outs_a()}, 32'b000011);
        check_eq("t3_cnt0", {24'd0, cnt_a}, 32'd0);

        // Clear in RUN at count 5
        if_a.target = 8'd50; if_a.start = 1'b1; step(); if_a.start = 1'b0;
        repeat (21) step();
        check_eq("t4_cnt5", {24'd0, cnt_a}, 32'd5);
        if_a.clear = 1'b1; step(); if_a.clear = 1'b0;
        check_eq("t4_clr_init", {26'd0, outs_a()}, 32'b010000);
        step();
        check_eq("t4_idle", {26'd0, outs_a()}, 32'd0);
        check_eq("t4_cnt0", {24'd0, cnt_a}, 32'd0);

        // start+stop in RUN pauses; start+stop in PAUSE stays paused
        if_a.target = 8'd50; if_a.start = 1'b1; step(); if_a.start = 1'b0;
        step();
        if_a.start = 1'b1; if_a.stop = 1'b1; step();
        check_eq("t5_pause", {26'd0, outs_a()}, 32'b000100);
        step();
        check_eq("t5_pause_hold", {26'd0, outs_a()}, 32'b000100);
        if_a.stop = 1'b0; step(); if_a.start = 1'b0;
        check_eq("t5_resume", {26'd0, outs_a()}, 32'b001000);

        // Asynchronous reset in the middle of a tick cycle
        waited = 0;
        while (!if_a.cnt_ce && waited < 10) begin
            step();
            waited++;
        end
        check_eq("t6_midtick", {31'd0, if_a.cnt_ce}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async", {26'd0, outs_a()}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check_eq("t6_no_init", {26'd0, outs_a()}, 32'd0);
        step();
        check_eq("t6_idle", {26'd0, outs_a()}, 32'd0);

        // Target 200 on the TICK_DIV=2 instance: free-run and wrap
        if_b.target = 8'd200; if_b.start = 1'b1; step(); if_b.start = 1'b0;
        check_eq("t7_init", {26'd0, outs_b()}, 32'b010000);
        bad  = 0;
        snap = 8'd0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (if_b.done || !if_b.busy) bad++;
            if (i == 199) snap = cnt_b;
        end
        check_eq("t7_no_done", bad, 32'd0);
        check_eq("t7_cnt99", {24'd0, snap}, 32'd99);
        step();
        check_eq("t7_wrap0", {24'd0, cnt_b}, 32'd0);
        check_eq("t7_busy", {26'd0, outs_b()}, 32'b001000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Run-control sequencer for the two-digit decimal up-counter (count range 0..99, binary-coded output).
It generates the counter's count-enable ticks from a programmable prescaler and drives the counter's synchronous init (load-to-zero).
It takes start/stop/clear commands, compares the counter value against a target latched at start, and flags completion.
It sits between the user command interface and a single counter instance.

Parameters:
TICK_DIV, 10, clocks per count tick; legal range 2..65535 (must be ≥2).
PRESC_W, 16, prescaler register width; must satisfy 2**PRESC_W ≥ TICK_DIV.

Ports:
clk        input   1   system clock, rising edge
rst_n      input   1   asynchronous active-low reset
start      input   1   level-sampled command: begin or resume counting
stop       input   1   level-sampled command: pause counting
clear      input   1   level-sampled command: zero the counter, return to idle
target     input   8   terminal count, binary; sampled when leaving IDLE/DONE on start
cnt_val    input   8   current counter value (binary 0..99) from the counter
cnt_ce     output  1   count-enable to counter; single-cycle pulse
cnt_init   output  1   synchronous load-to-zero to counter; single-cycle pulse
busy       output  1   high in RUN
paused     output  1   high in PAUSE
done       output  1   high in DONE (level)
done_pulse output  1   high for exactly the first cycle of DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; prescaler=0; target_q=0.
  - All outputs are 0 immediately, with no clock required.
  - Reset mid-operation abandons the run; no cnt_init is issued on release.
- States: IDLE, INIT, RUN, PAUSE, DONE. All outputs are decoded from registered state/prescaler only (Moore).
- Command priority, evaluated every edge: clear > stop > start. Commands not listed for a state are ignored.
- IDLE:
  - start → INIT, latch target_q=target.
  - clear → INIT (a clear-originated INIT returns to IDLE).
- INIT:
  - One cycle with cnt_init=1, cnt_ce=0; prescaler forced to 0.
  - Next state is RUN if entered via start, IDLE if entered via clear. A 1-bit origin flag records which.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - cnt_ce=1 when prescaler==TICK_DIV-1, so the first tick occurs TICK_DIV cycles after entering RUN.
  - clear → INIT (clear origin). stop → PAUSE.
  - A stop sampled in a cycle where cnt_ce=1 does not suppress that increment.
  - If target_q ≤ 99, cnt_val==target_q and cnt_ce==0 → DONE.
  - Compare latency: the counter updates on the cnt_ce edge, the match is seen the following cycle, and DONE is entered one edge later.
  - target_q=0 → DONE after exactly one RUN cycle, with no cnt_ce.
  - target_q > 99 → free-run: the counter wraps 99→0 and DONE is never entered.
- PAUSE:
  - Prescaler holds its value; cnt_ce=0.
  - start → RUN; prescaler resumes from the held value; target_q is not re-sampled.
  - clear → INIT (clear origin).
  - start and stop together in PAUSE → remain in PAUSE.
- DONE:
  - cnt_ce=0 and cnt_val is held.
  - start → INIT (re-latches target; run origin).
  - clear → INIT (clear origin).
  - done_pulse is registered and high only on the first DONE cycle.
- Simultaneous start+stop in RUN → PAUSE. start+clear in any state → clear path.
- cnt_ce and cnt_init are never high in the same cycle.
- Prescaler width arithmetic is unsigned, and the terminal compare uses TICK_DIV-1 truncated to PRESC_W.

Decomposition:
- Shared package/include bcd_ctrl_pkg holds:
  - state encoding localparams (ST_IDLE, ST_INIT, ST_RUN, ST_PAUSE, ST_DONE; 3 bits);
  - BCD_MAX=99.
- One sub-module: tick_gen, the prescaler.
  - Inputs: clk, rst_n, run, sync clear.
  - Output: single-cycle tick, parameterised by TICK_DIV/PRESC_W.
- FSM, target latch, compare and output decode live in the top.

Test Plan:
- TICK_DIV=4, target=3, pulse start:
  - cnt_init pulses once, then cnt_ce pulses at RUN cycles 4, 8, 12.
  - cnt_val goes 0→1→2→3.
  - done rises 2 cycles after the third tick, done_pulse is high for 1 cycle, no further cnt_ce.
- TICK_DIV=4, target=10:
  - stop after the 2nd tick, holding prescaler at k, wait 20 cycles: no cnt_ce, paused=1.
  - start: the next tick arrives 4-k cycles later, and the run completes at cnt_val=10.
- Start with target=0 → DONE after one RUN cycle.
- Start with target=200, TICK_DIV=2:
  - after 100 ticks cnt_val wraps 99→0;
  - done never asserts and busy stays 1.
- Clear asserted in RUN at cnt_val=5 → one cnt_init cycle, cnt_val=0, state IDLE, busy=0.
- rst_n low asynchronously mid-tick → all outputs 0 within the same cycle; after release, IDLE with no cnt_init.
- start+stop together in RUN → PAUSE.
